mips_run_checker: RTL and testbench

- Synthesizable run controller and self-checker for the multicycle MIPS `top`.
- Sequences the processor's reset and watches the data-memory write bus (memwrite, adr, writedata).
- Compares observed stores against a loadable table of expected writes and reports pass/fail with diagnostics.
- Replaces the open-ended reset/clock-only bench: adds a parametrised expected-write sequence, two check modes, a timeout watchdog and DUT freeze on completion. Usable in simulation and on FPGA.

---
 rtl/mips_run_checker.sv | 186 ++++++++++++++++++
 tb/tb_mips_run_checker.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mips_run_checker.sv
// Run controller and store checker for the multicycle MIPS core.
// Holds the core in reset for a fixed number of cycles, releases it, then
// compares every data-memory store against a loadable table of expected
// writes. Ends in PASS or FAIL (mismatch or watchdog), re-asserting the
// core reset so its state is frozen for inspection.
module mips_run_checker #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int DEPTH        = 8,
  parameter int RESET_CYCLES = 2,
  parameter int TIMEOUT      = 1000,
  parameter int ORDERED      = 1,
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          exp_we,
  input  logic [IW-1:0] exp_idx,
  input  logic [AW-1:0] exp_adr,
  input  logic [DW-1:0] exp_data,
  input  logic [LW-1:0] exp_len,
  input  logic          memwrite,
  input  logic [AW-1:0] adr,
  input  logic [DW-1:0] writedata,
  output logic          cpu_reset,
  output logic          done,
  output logic          pass,
  output logic          fail,
  output logic          timeout,
  output logic [IW-1:0] fail_idx,
  output logic [AW-1:0] fail_adr,
  output logic [DW-1:0] fail_data,
  output logic [LW-1:0] match_count,
  output logic [31:0]   cycle_count
);

  localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [31:0]   TMO_L   = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_RUN, S_PASS, S_FAIL} state_t;

  state_t        r_state, w_state_n;
  logic [AW-1:0] r_tab_adr  [DEPTH];
  logic [DW-1:0] r_tab_data [DEPTH];
  logic [IW-1:0] r_ptr, w_ptr_n;
  logic [HW-1:0] r_hold, w_hold_n;
  logic [LW-1:0] r_match, w_match_n;
  logic [31:0]   r_cycle, w_cycle_n;
  logic [IW-1:0] r_fail_idx, w_fail_idx_n;
  logic [AW-1:0] r_fail_adr, w_fail_adr_n;
  logic [DW-1:0] r_fail_data, w_fail_data_n;
  logic          r_timeout, w_timeout_n;
  logic          r_cpu_reset, r_done, r_pass, r_fail;

  logic [LW-1:0] w_len;
  logic [IW-1:0] w_last;
  logic          w_is_last, w_hit_ptr, w_hit_last, w_tmo;

  // Effective table length (clamped) and the store-match terms.
  always_comb begin
    w_len      = (exp_len > DEPTH_L) ? DEPTH_L : exp_len;
    w_last     = (w_len == '0) ? '0 : IW'(w_len - LW'(1));
    w_is_last  = (r_ptr == w_last);
    w_hit_ptr  = memwrite && (adr == r_tab_adr[r_ptr]) &&
                 (writedata == r_tab_data[r_ptr]);
    w_hit_last = memwrite && (adr == r_tab_adr[w_last]) &&
                 (writedata == r_tab_data[w_last]);
    w_tmo      = (r_cycle == TMO_L);
  end

  // Expected-write table: writable only while idle, never cleared by reset
  // so a rerun after reset needs only start.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && exp_we && (int'(exp_idx) < DEPTH)) begin
      r_tab_adr[exp_idx]  <= exp_adr;
      r_tab_data[exp_idx] <= exp_data;
    end
  end

  // Next-state and next-value logic for the run sequencer.
  always_comb begin
    w_state_n     = r_state;
    w_ptr_n       = r_ptr;
    w_hold_n      = r_hold;
    w_match_n     = r_match;
    w_cycle_n     = r_cycle;
    w_fail_idx_n  = r_fail_idx;
    w_fail_adr_n  = r_fail_adr;
    w_fail_data_n = r_fail_data;
    w_timeout_n   = r_timeout;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_n = S_HOLD;
          w_hold_n  = HW'(RESET_CYCLES - 1);
        end
      end
      S_HOLD: begin
        if (r_hold == '0) w_state_n = S_RUN;
        else              w_hold_n  = r_hold - HW'(1);
      end
      S_RUN: begin
        if (w_len == '0) begin
          w_state_n = S_PASS;
        end else if (ORDERED != 0) begin
          if (memwrite) begin
            if (w_hit_ptr) begin
              w_match_n = r_match + LW'(1);
              if (w_is_last) w_state_n = S_PASS;
              else           w_ptr_n   = r_ptr + IW'(1);
            end else begin
              // A wrong store wins over the watchdog on the same cycle.
              w_state_n     = S_FAIL;
              w_fail_idx_n  = r_ptr;
              w_fail_adr_n  = adr;
              w_fail_data_n = writedata;
            end
          end
        end else if (w_hit_last) begin
          w_state_n = S_PASS;
          w_match_n = LW'(1);
        end
        // Still running means neither pass nor mismatch happened this cycle.
        if (w_state_n == S_RUN && w_tmo) begin
          w_state_n     = S_FAIL;
          w_timeout_n   = 1'b1;
          w_fail_idx_n  = w_ptr_n;
          w_fail_adr_n  = '0;
          w_fail_data_n = '0;
        end
        // Counter freezes on the terminating cycle.
        if (w_state_n == S_RUN && r_cycle != '1) w_cycle_n = r_cycle + 32'd1;
      end
      default: ;  // PASS/FAIL are terminal until reset
    endcase
  end

  // State and output registers; outputs are derived from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_hold      <= '0;
      r_match     <= '0;
      r_cycle     <= '0;
      r_fail_idx  <= '0;
      r_fail_adr  <= '0;
      r_fail_data <= '0;
      r_timeout   <= 1'b0;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_ptr       <= w_ptr_n;
      r_hold      <= w_hold_n;
      r_match     <= w_match_n;
      r_cycle     <= w_cycle_n;
      r_fail_idx  <= w_fail_idx_n;
      r_fail_adr  <= w_fail_adr_n;
      r_fail_data <= w_fail_data_n;
      r_timeout   <= w_timeout_n;
      r_cpu_reset <= (w_state_n != S_RUN);
      r_done      <= (w_state_n == S_PASS) || (w_state_n == S_FAIL);
      r_pass      <= (w_state_n == S_PASS);
      r_fail      <= (w_state_n == S_FAIL);
    end
  end

  assign cpu_reset   = r_cpu_reset;
  assign done        = r_done;
  assign pass        = r_pass;
  assign fail        = r_fail;
  assign timeout     = r_timeout;
  assign fail_idx    = r_fail_idx;
  assign fail_adr    = r_fail_adr;
  assign fail_data   = r_fail_data;
  assign match_count = r_match;
  assign cycle_count = r_cycle;

endmodule

// File: tb/tb_mips_run_checker.sv
// Directed bench for mips_run_checker: an ordered checker with a short
// watchdog and an unordered checker share all inputs.
module tb_mips_run_checker;

  logic        clk = 1'b0;
  logic        reset, start, exp_we, memwrite;
  logic [2:0]  exp_idx;
  logic [31:0] exp_adr, exp_data, adr, writedata;
  logic [3:0]  exp_len;

  logic        a_cpu_reset, a_done, a_pass, a_fail, a_timeout;
  logic [2:0]  a_fail_idx;
  logic [31:0] a_fail_adr, a_fail_data, a_cycle;
  logic [3:0]  a_match;
  logic        b_cpu_reset, b_done, b_pass, b_fail, b_timeout;
  logic [2:0]  b_fail_idx;
  logic [31:0] b_fail_adr, b_fail_data, b_cycle;
  logic [3:0]  b_match;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mips_run_checker #(.DEPTH(8), .RESET_CYCLES(2), .TIMEOUT(20), .ORDERED(1)) u_ord (
    .clk(clk), .reset(reset), .start(start), .exp_we(exp_we), .exp_idx(exp_idx),
    .exp_adr(exp_adr), .exp_data(exp_data), .exp_len(exp_len), .memwrite(memwrite),
    .adr(adr), .writedata(writedata), .cpu_reset(a_cpu_reset), .done(a_done),
    .pass(a_pass), .fail(a_fail), .timeout(a_timeout), .fail_idx(a_fail_idx),
    .fail_adr(a_fail_adr), .fail_data(a_fail_data), .match_count(a_match),
    .cycle_count(a_cycle));

  mips_run_checker #(.DEPTH(8), .RESET_CYCLES(2), .TIMEOUT(1000), .ORDERED(0)) u_un (
    .clk(clk), .reset(reset), .start(start), .exp_we(exp_we), .exp_idx(exp_idx),
    .exp_adr(exp_adr), .exp_data(exp_data), .exp_len(exp_len), .memwrite(memwrite),
    .adr(adr), .writedata(writedata), .cpu_reset(b_cpu_reset), .done(b_done),
    .pass(b_pass), .fail(b_fail), .timeout(b_timeout), .fail_idx(b_fail_idx),
    .fail_adr(b_fail_adr), .fail_data(b_fail_data), .match_count(b_match),
    .cycle_count(b_cycle));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic load(input logic [2:0] i, input logic [31:0] a, input logic [31:0] d);
    exp_we = 1'b1; exp_idx = i; exp_adr = a; exp_data = d; tick(); exp_we = 1'b0;
  endtask

  task automatic load_std();
    load(3'd0, 32'h50, 32'd7); load(3'd1, 32'h54, 32'd1); load(3'd2, 32'h58, 32'd2);
  endtask

  // start edge plus two hold cycles: afterwards the DUT is in its first RUN cycle
  task automatic run_start();
    start = 1'b1; tick(); start = 1'b0; tick(); tick();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; adr = a; writedata = d; tick(); memwrite = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (a_cpu_reset !== 1'b1) begin n_bad++; $display("FAIL rst_cpu_reset got %0b want 1", a_cpu_reset); end
    n_cmp++; if ({a_done, a_pass, a_fail, a_timeout} !== 4'b0) begin n_bad++; $display("FAIL rst_flags got %b want 0000", {a_done, a_pass, a_fail, a_timeout}); end
    n_cmp++; if (a_match !== 4'd0 || a_cycle !== 32'd0) begin n_bad++; $display("FAIL rst_counters got %0d/%0d want 0/0", a_match, a_cycle); end
    n_cmp++; if (a_fail_idx !== 3'd0 || a_fail_adr !== 32'd0 || a_fail_data !== 32'd0) begin n_bad++; $display("FAIL rst_diag got %0d/%h/%h want 0", a_fail_idx, a_fail_adr, a_fail_data); end
  endtask

  task automatic test_ordered_pass();
    do_reset(); load_std(); exp_len = 4'd3;
    start = 1'b1; tick(); start = 1'b0;
    n_cmp++; if (a_cpu_reset !== 1'b1) begin n_bad++; $display("FAIL hold1_cpu_reset got %0b want 1", a_cpu_reset); end
    tick();
    n_cmp++; if (a_cpu_reset !== 1'b1) begin n_bad++; $display("FAIL hold2_cpu_reset got %0b want 1", a_cpu_reset); end
    tick();
    n_cmp++; if (a_cpu_reset !== 1'b0) begin n_bad++; $display("FAIL run_cpu_reset got %0b want 0", a_cpu_reset); end
    store(32'h50, 32'd7); store(32'h54, 32'd1);
    n_cmp++; if (a_done !== 1'b0 || a_match !== 4'd2) begin n_bad++; $display("FAIL ord_mid got done=%0b match=%0d want 0/2", a_done, a_match); end
    store(32'h58, 32'd2);
    n_cmp++; if ({a_done, a_pass, a_fail} !== 3'b110) begin n_bad++; $display("FAIL ord_pass got %b want 110", {a_done, a_pass, a_fail}); end
    n_cmp++; if (a_match !== 4'd3 || a_cycle !== 32'd2) begin n_bad++; $display("FAIL ord_counts got %0d/%0d want 3/2", a_match, a_cycle); end
    n_cmp++; if (a_cpu_reset !== 1'b1) begin n_bad++; $display("FAIL ord_freeze got %0b want 1", a_cpu_reset); end
    start = 1'b1; store(32'h60, 32'd9); start = 1'b0; tick();
    n_cmp++; if ({a_done, a_pass, a_fail, a_cpu_reset} !== 4'b1101 || a_match !== 4'd3) begin n_bad++; $display("FAIL ord_terminal got %b m=%0d want 1101 m=3", {a_done, a_pass, a_fail, a_cpu_reset}, a_match); end
  endtask

  task automatic test_ordered_mismatch();
    do_reset(); exp_len = 4'd3; run_start();
    store(32'h50, 32'd7); store(32'h54, 32'd9);
    n_cmp++; if ({a_done, a_pass, a_fail, a_timeout} !== 4'b1010) begin n_bad++; $display("FAIL mm_flags got %b want 1010", {a_done, a_pass, a_fail, a_timeout}); end
    n_cmp++; if (a_fail_idx !== 3'd1 || a_fail_adr !== 32'h54 || a_fail_data !== 32'd9) begin n_bad++; $display("FAIL mm_diag got %0d/%h/%0d want 1/54/9", a_fail_idx, a_fail_adr, a_fail_data); end
    n_cmp++; if (a_match !== 4'd1) begin n_bad++; $display("FAIL mm_match got %0d want 1", a_match); end
  endtask

  task automatic test_unordered();
    do_reset(); load(3'd0, 32'd84, 32'd7); exp_len = 4'd1; run_start();
    store(32'd80, 32'd3); store(32'd60, 32'd5);
    n_cmp++; if (b_done !== 1'b0 || b_match !== 4'd0) begin n_bad++; $display("FAIL un_ignore got done=%0b m=%0d want 0/0", b_done, b_match); end
    store(32'd84, 32'd7);
    n_cmp++; if ({b_done, b_pass, b_fail} !== 3'b110 || b_match !== 4'd1) begin n_bad++; $display("FAIL un_pass got %b m=%0d want 110 m=1", {b_done, b_pass, b_fail}, b_match); end
  endtask

  task automatic test_timeout();
    do_reset(); load_std(); exp_len = 4'd3; run_start();
    repeat (19) tick();
    n_cmp++; if (a_done !== 1'b0 || a_cycle !== 32'd19) begin n_bad++; $display("FAIL tmo_early got done=%0b cyc=%0d want 0/19", a_done, a_cycle); end
    tick();
    n_cmp++; if ({a_done, a_pass, a_fail, a_timeout} !== 4'b1011) begin n_bad++; $display("FAIL tmo_flags got %b want 1011", {a_done, a_pass, a_fail, a_timeout}); end
    n_cmp++; if (a_cycle !== 32'd19 || a_fail_idx !== 3'd0 || a_fail_adr !== 32'd0) begin n_bad++; $display("FAIL tmo_diag got cyc=%0d idx=%0d adr=%h want 19/0/0", a_cycle, a_fail_idx, a_fail_adr); end
  endtask

  task automatic test_timeout_edge();
    do_reset(); exp_len = 4'd1; run_start();
    repeat (19) tick(); store(32'h50, 32'd7);
    n_cmp++; if ({a_pass, a_fail, a_timeout} !== 3'b100 || a_cycle !== 32'd19) begin n_bad++; $display("FAIL tmo_pass got %b cyc=%0d want 100/19", {a_pass, a_fail, a_timeout}, a_cycle); end
    do_reset(); run_start();
    repeat (19) tick(); store(32'h60, 32'd1);
    n_cmp++; if ({a_pass, a_fail, a_timeout} !== 3'b010 || a_fail_adr !== 32'h60 || a_fail_data !== 32'd1) begin n_bad++; $display("FAIL tmo_mm got %b adr=%h d=%0d want 010/60/1", {a_pass, a_fail, a_timeout}, a_fail_adr, a_fail_data); end
  endtask

  task automatic test_len_zero();
    do_reset(); exp_len = 4'd0; run_start();
    n_cmp++; if (a_done !== 1'b0) begin n_bad++; $display("FAIL len0_first got done=%0b want 0", a_done); end
    tick();
    n_cmp++; if ({a_done, a_pass, a_fail} !== 3'b110 || a_match !== 4'd0) begin n_bad++; $display("FAIL len0_pass got %b m=%0d want 110/0", {a_done, a_pass, a_fail}, a_match); end
  endtask

  task automatic test_reset_midrun();
    do_reset(); exp_len = 4'd3; run_start();
    store(32'h50, 32'd7);
    load(3'd1, 32'h54, 32'hFF);
    n_cmp++; if (a_match !== 4'd1 || a_done !== 1'b0) begin n_bad++; $display("FAIL mid_match got m=%0d done=%0b want 1/0", a_match, a_done); end
    do_reset();
    n_cmp++; if ({a_cpu_reset, a_done, a_pass, a_fail} !== 4'b1000 || a_match !== 4'd0 || a_cycle !== 32'd0) begin n_bad++; $display("FAIL mid_reset got %b m=%0d cyc=%0d want 1000/0/0", {a_cpu_reset, a_done, a_pass, a_fail}, a_match, a_cycle); end
    run_start();
    store(32'h50, 32'd7); store(32'h54, 32'd1); store(32'h58, 32'd2);
    n_cmp++; if ({a_done, a_pass, a_fail} !== 3'b110 || a_match !== 4'd3) begin n_bad++; $display("FAIL mid_rerun got %b m=%0d want 110/3", {a_done, a_pass, a_fail}, a_match); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; exp_we = 1'b0; memwrite = 1'b0;
    exp_idx = '0; exp_adr = '0; exp_data = '0; adr = '0; writedata = '0; exp_len = '0;
    tick();
    test_reset();
    test_ordered_pass();
    test_ordered_mismatch();
    test_unordered();
    test_timeout();
    test_timeout_edge();
    test_len_zero();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
